adder_share_ctrl: RTL and testbench

- Two-requester controller that time-shares one 6-bit ripple adder instance (ports x, y, sum; no carry-out).
- Arbitrates requests round-robin, latches the winner's operands and sequences each add through a 3-state FSM.
- Returns a registered result, a derived carry-out and a per-requester done pulse.
- Keeps a wrapping count of completed operations; sits between client blocks and the adder datapath.

---
 rtl/adder_share_ctrl.sv | 80 ++++++++
 tb/tb_adder_share_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: round-robin two-requester controller time-sharing one 6-bit ripple adder
module ripple_add6 (
  input  logic [5:0] x,
  input  logic [5:0] y,
  output logic [5:0] sum
);
  logic [5:0] w_c;
  assign w_c[0] = 1'b0;
  for (genvar i = 0; i < 6; i++) begin : g_fa
    assign sum[i] = x[i] ^ y[i] ^ w_c[i];
    if (i < 5) begin : g_c
      assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end
  end
endmodule

module adder_share_ctrl #(
  parameter bit FIRST_PRIO = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [5:0]       a0,
  input  logic [5:0]       b0,
  input  logic             req1,
  input  logic [5:0]       a1,
  input  logic [5:0]       b1,
  output logic             done0,
  output logic             done1,
  output logic [5:0]       result,
  output logic             carry,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;
  state_t     r_state, w_next;
  logic [5:0] r_x, r_y, w_sum;
  logic       r_win, r_last, w_win, w_req;
  ripple_add6 u_add (.x(r_x), .y(r_y), .sum(w_sum));
  assign w_req = req0 | req1;
  assign w_win = (req0 & req1) ? ~r_last : req1;
  always_comb begin
    w_next = IDLE;
    busy   = 1'b0;
    done0  = 1'b0;
    done1  = 1'b0;
    w_next = (r_state == IDLE) ? (w_req ? ADD : IDLE) : (r_state == ADD) ? RESP : IDLE;
    busy   = r_state != IDLE;
    done0  = (r_state == RESP) & ~r_win;
    done1  = (r_state == RESP) & r_win;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_win    <= 1'b0;
      r_last   <= ~FIRST_PRIO;
      result   <= '0;
      carry    <= 1'b0;
      op_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_req) begin
        r_x   <= w_win ? a1 : a0;
        r_y   <= w_win ? b1 : b0;
        r_win <= w_win;
      end
      if (r_state == ADD) begin
        result <= w_sum;
        carry  <= (r_x[5] & r_y[5]) | ((r_x[5] ^ r_y[5]) & ~w_sum[5]);
      end
      if (r_state == RESP) begin
        op_count <= op_count + CNT_W'(1);
        r_last   <= r_win;
      end
    end
  end
endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb_adder_share_ctrl: directed stimulus checked against a cycle-level model of the shared-adder controller
module tb_adder_share_ctrl;
  localparam bit FP = 1'b0;
  logic       clk = 1'b0, reset = 1'b1, req0 = 1'b0, req1 = 1'b0;
  logic [5:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       done0, done1, carry, busy;
  logic [5:0] result;
  logic [7:0] op_count;
  int         total = 0, bad = 0, cyc = 0;
  bit         cmp_on = 1'b0;
  int         m_left = 0, m_a = 0, m_b = 0, m_res = 0, m_cnt = 0;
  bit         m_win = 1'b0, m_last = 1'b0, m_car = 1'b0;
  adder_share_ctrl #(.FIRST_PRIO(FP), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1),
    .result(result), .carry(carry), .busy(busy), .op_count(op_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(posedge clk) begin
    if (reset) begin
      m_left = 0;
      m_last = ~FP;
      m_res  = 0;
      m_car  = 1'b0;
      m_cnt  = 0;
    end else if (m_left == 2) begin
      m_res  = (m_a + m_b) % 64;
      m_car  = (m_a + m_b) > 63;
      m_left = 1;
    end else if (m_left == 1) begin
      m_cnt  = (m_cnt + 1) % 256;
      m_last = m_win;
      m_left = 0;
    end else if (req0 || req1) begin
      m_win  = (req0 && req1) ? !m_last : req1;
      m_a    = m_win ? int'(a1) : int'(a0);
      m_b    = m_win ? int'(b1) : int'(b0);
      m_left = 2;
    end
  end
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("busy", busy, m_left != 0);
      chk("done0", done0, m_left == 1 && !m_win);
      chk("done1", done1, m_left == 1 && m_win);
      chk("result", result, m_res);
      chk("carry", carry, m_car);
      chk("op_count", op_count, m_cnt);
      chk("done_excl", done0 & done1, 0);
    end
  end
  task automatic wait_done(input bit who, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(who ? done1 : done0) && n < 12);
    chk("done_timeout", n < 12, 1);
  endtask
  task automatic do_op(input bit who, input logic [5:0] a, input logic [5:0] b, input logic [5:0] er, input logic ec);
    int n;
    @(negedge clk);
    if (who) begin
      req1 = 1'b1;
      a1 = a;
      b1 = b;
    end else begin
      req0 = 1'b1;
      a0 = a;
      b0 = b;
    end
    wait_done(who, n);
    chk("latency", n, 2);
    chk("op_result", result, er);
    chk("op_carry", carry, ec);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask
  initial begin
    int n, last, ops;
    bit w;
    @(negedge clk);
    cmp_on = 1'b1;
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", op_count, 0);
    chk("rst_done", done0 | done1, 0);
    reset = 1'b0;
    do_op(1'b0, 6'd1, 6'd0, 6'd1, 1'b0);
    @(negedge clk);
    chk("count_one", op_count, 1);
    do_op(1'b1, 6'd1, 6'd1, 6'd2, 1'b0);
    repeat (3) @(negedge clk);
    chk("result_hold", result, 2);
    do_op(1'b0, 6'd63, 6'd1, 6'd0, 1'b1);
    do_op(1'b0, 6'd32, 6'd32, 6'd0, 1'b1);
    do_op(1'b0, 6'd31, 6'd1, 6'd32, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(done0 || done1) && n < 12);
      chk("rr_timeout", n < 12, 1);
      w = done1;
      chk("rr_grant", w, i % 2);
      if (i > 0) chk("rr_gap", cyc - last, 3);
      last = cyc;
      if (w) req1 = 1'b0;
      else req0 = 1'b0;
      @(negedge clk);
      if (w) req1 = 1'b1;
      else req0 = 1'b1;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    req0 = 1'b1;
    a0 = 6'd5;
    b0 = 6'd5;
    @(negedge clk);
    chk("abort_in_add", busy, 1);
    reset = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_done", done0, 0);
    chk("abort_count", op_count, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_idle", busy | done0, 0);
    req0 = 1'b1;
    a0 = 6'd10;
    b0 = 6'd3;
    @(negedge clk);
    a0 = 6'd50;
    @(negedge clk);
    chk("latched_done", done0, 1);
    chk("latched_result", result, 13);
    ops = 1;
    n = 0;
    while (ops < 256 && n < 2000) begin
      @(negedge clk);
      n++;
      a0 = a0 + 6'd7;
      if (done0) begin
        ops++;
        if (ops == 256) chk("pre_wrap", op_count, 255);
      end
    end
    chk("wrap_timeout", ops, 256);
    req0 = 1'b0;
    @(negedge clk);
    chk("wrap", op_count, 0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
